// File: rtl/rtc_pkg.sv
// rtc_pkg: shared RTC alarm state encoding, BCD digit limits and timer width
package rtc_pkg;
  typedef enum logic [1:0] {
    ALM_DISARMED = 2'd0,
    ALM_ARMED    = 2'd1,
    ALM_RINGING  = 2'd2,
    ALM_SNOOZE   = 2'd3
  } alm_state_t;
  localparam logic [3:0] MAX_HR_TENS        = 4'd2;
  localparam logic [3:0] MAX_HR_UNITS_AT_20 = 4'd3;
  localparam logic [3:0] MAX_MIN_TENS       = 4'd5;
  localparam logic [3:0] MAX_DIGIT          = 4'd9;
  localparam int TMR_W = 12;
endpackage

// File: rtl/rtc_bcd_time_valid.sv
// rtc_bcd_time_valid: combinational legality check of an HH:MM BCD time
module rtc_bcd_time_valid
  import rtc_pkg::*;
(
  input  logic [3:0] i_hrm,
  input  logic [3:0] i_hrl,
  input  logic [3:0] i_minm,
  input  logic [3:0] i_minl,
  output logic       o_valid
);
  assign o_valid = i_hrm <= MAX_HR_TENS && i_hrl <= MAX_DIGIT &&
                   (i_hrm != MAX_HR_TENS || i_hrl <= MAX_HR_UNITS_AT_20) &&
                   i_minm <= MAX_MIN_TENS && i_minl <= MAX_DIGIT;
endmodule

// File: rtl/rtc_alarm_ctrl.sv
// rtc_alarm_ctrl: HH:MM alarm with ring timeout, bounded snooze, dismiss and disarm
module rtc_alarm_ctrl
  import rtc_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic [3:0] hrm,
  input  logic [3:0] hrl,
  input  logic [3:0] minm,
  input  logic [3:0] minl,
  input  logic [3:0] secm,
  input  logic [3:0] secl,
  input  logic       set_en,
  input  logic [3:0] set_hrm,
  input  logic [3:0] set_hrl,
  input  logic [3:0] set_minm,
  input  logic [3:0] set_minl,
  input  logic       arm,
  input  logic       disarm,
  input  logic       dismiss,
  input  logic       snooze,
  output logic [3:0] al_hrm,
  output logic [3:0] al_hrl,
  output logic [3:0] al_minm,
  output logic [3:0] al_minl,
  output logic       ring,
  output logic       armed,
  output logic       snoozing,
  output logic       set_err
);
  localparam logic [TMR_W-1:0] RING_LD = TMR_W'(RING_SECS - 1);
  localparam logic [TMR_W-1:0] SNZ_LD  = TMR_W'(SNOOZE_SECS - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [2:0]       SNZ_MAX = 3'(MAX_SNOOZE);
  alm_state_t       r_state, w_nstate;
  logic [TMR_W-1:0] r_ring_tmr, w_ring_tmr, r_snz_tmr, w_snz_tmr;
  logic [2:0]       r_snz_left, w_snz_left;
  logic [15:0]      r_al;
  logic             r_ring, r_armed, r_snoozing, r_set_err;
  logic             w_set_ok, w_match, w_live;
  rtc_bcd_time_valid u_set_chk (
    .i_hrm  (set_hrm),
    .i_hrl  (set_hrl),
    .i_minm (set_minm),
    .i_minl (set_minl),
    .o_valid(w_set_ok)
  );
  assign w_match = {hrm, hrl, minm, minl} == r_al && secm == 4'd0 && secl == 4'd0;
  assign w_live  = r_state == ALM_RINGING || r_state == ALM_SNOOZE;
  // One if-chain encodes the per-edge priority; timers then count down only while staying put
  always_comb begin
    w_nstate   = r_state;
    w_ring_tmr = r_ring_tmr;
    w_snz_tmr  = r_snz_tmr;
    w_snz_left = r_snz_left;
    if (disarm) w_nstate = ALM_DISARMED;
    else if (set_en) w_nstate = (w_set_ok && w_live) ? ALM_ARMED : r_state;
    else if (dismiss && w_live) w_nstate = ALM_ARMED;
    else if (snooze && r_state == ALM_RINGING && r_snz_left != 3'd0) begin
      w_nstate   = ALM_SNOOZE;
      w_snz_tmr  = SNZ_LD;
      w_snz_left = r_snz_left - 3'd1;
    end
    else if (r_state == ALM_RINGING && r_ring_tmr == '0) w_nstate = ALM_ARMED;
    else if (r_state == ALM_SNOOZE && r_snz_tmr == '0) begin
      w_nstate   = ALM_RINGING;
      w_ring_tmr = RING_LD;
    end
    else if (r_state == ALM_ARMED && w_match) begin
      w_nstate   = ALM_RINGING;
      w_ring_tmr = RING_LD;
      w_snz_left = SNZ_MAX;
    end
    else if (r_state == ALM_DISARMED && arm) w_nstate = ALM_ARMED;
    w_ring_tmr = (r_state == ALM_RINGING && w_nstate == ALM_RINGING && r_ring_tmr != '0) ?
                 r_ring_tmr - TMR_ONE : w_ring_tmr;
    w_snz_tmr  = (r_state == ALM_SNOOZE && w_nstate == ALM_SNOOZE && r_snz_tmr != '0) ?
                 r_snz_tmr - TMR_ONE : w_snz_tmr;
  end
  always_ff @(posedge clk_1hz) begin
    if (!rst) begin
      r_state    <= ALM_DISARMED;
      r_ring_tmr <= '0;
      r_snz_tmr  <= '0;
      r_snz_left <= '0;
      r_al       <= '0;
      r_ring     <= 1'b0;
      r_armed    <= 1'b0;
      r_snoozing <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_ring_tmr <= w_ring_tmr;
      r_snz_tmr  <= w_snz_tmr;
      r_snz_left <= w_snz_left;
      r_al       <= (set_en && w_set_ok) ? {set_hrm, set_hrl, set_minm, set_minl} : r_al;
      r_ring     <= w_nstate == ALM_RINGING;
      r_armed    <= w_nstate != ALM_DISARMED;
      r_snoozing <= w_nstate == ALM_SNOOZE;
      r_set_err  <= set_en && !w_set_ok;
    end
  end
  assign {al_hrm, al_hrl, al_minm, al_minl} = r_al;
  assign ring     = r_ring;
  assign armed    = r_armed;
  assign snoozing = r_snoozing;
  assign set_err  = r_set_err;
endmodule
